// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory read bus and decode handshake for fetch_queue.
// master = fetch unit side, slave = memory/decode side.
interface fetch_queue_if #(
   parameter int unsigned XLEN = 32
);
   // memory read port
   logic            request;
   logic            we_re;
   logic [3:0]      mask;
   logic [XLEN-1:0] address_out;
   logic            valid;
   logic [31:0]     instruction_fetch;
   // decode handshake
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instruction;
   logic [XLEN-1:0] instr_pc;

   modport master (
      output request, we_re, mask, address_out,
      input  valid, instruction_fetch,
      output instr_valid, instruction, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  request, we_re, mask, address_out,
      output valid, instruction_fetch,
      input  instr_valid, instruction, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a DEPTH-entry prefetch queue.
// Issues word reads while (in flight + buffered) < DEPTH, tags in-order
// responses with their PC, and flushes on redirect. Responses belonging to
// requests issued before a redirect are counted in drop_cnt and discarded.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect halts fetch
// and raises a sticky flag until the next aligned redirect).
module fetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   fetch_queue_if.master     bus,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_address,
   output logic              misaligned
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     data_mem [DEPTH];

   logic [CW:0]     occupancy;
   logic            resp;
   logic            drop;
   logic            push;
   logic            pop;
   logic            issue;
   logic            halt;
   logic [XLEN-1:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned_q;

   assign target     = redirect_address;
   assign halt       = misaligned_q;
   assign misaligned = misaligned_q;

   // sticky flag: set by a misaligned redirect, cleared by an aligned one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misaligned_q <= 1'b0;
      end else if (redirect) begin
         misaligned_q <= (redirect_address[1:0] != 2'b00);
      end
   end
`else
   assign target     = {redirect_address[XLEN-1:2], 2'b00};
   assign halt       = 1'b0;
   assign misaligned = 1'b0;
`endif

   // per-cycle events; a response seen with nothing in flight is ignored
   always_comb begin
      occupancy = {1'b0, inflight} + {1'b0, count};
      resp      = bus.valid && (inflight != '0);
      drop      = resp && (drop_cnt != '0);
      push      = resp && !drop && !redirect;
      pop       = (count != '0) && bus.instr_ready && !redirect;
      issue     = rst && !redirect && !halt && (occupancy < DEPTH_C);
   end

   assign bus.request     = issue;
   assign bus.we_re       = 1'b0;
   assign bus.mask        = 4'b1111;
   assign bus.address_out = pc;
   assign bus.instr_valid = (count != '0);
   assign bus.instruction = data_mem[rd_ptr];
   assign bus.instr_pc    = pc_mem[rd_ptr];

   // control state: PCs, counters, pointers; redirect overrides issue/push/pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect) begin
         // everything still outstanding after this cycle's response is stale
         pc       <= target;
         resp_pc  <= target;
         inflight <= inflight - CW'(resp);
         drop_cnt <= drop_cnt + inflight - CW'(resp);
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         if (issue) begin
            pc <= pc + XLEN'(4);
         end
         inflight <= inflight + CW'(issue) - CW'(resp);
         if (drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (push) begin
            resp_pc <= resp_pc + XLEN'(4);
            wr_ptr  <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // queue storage: {pc, instruction} written at the tail on each live response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]   <= resp_pc;
         data_mem[wr_ptr] <= bus.instruction_fetch;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test of fetch_queue with a fixed-latency memory
// model returning ~address as instruction data.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_address;
   logic        misaligned;

   int unsigned n_asrt = 0;
   int unsigned n_fail = 0;
   int unsigned issued = 0;
   int unsigned n0;
   int unsigned lat = 1;
   int unsigned cyc = 0;

   typedef struct {
      int unsigned due;
      logic [31:0] addr;
   } rsp_t;
   rsp_t mq[$];

   fetch_queue_if #(.XLEN(32)) bus ();

   fetch_queue #(
      .XLEN    (32),
      .DEPTH   (4),
      .RESET_PC(32'h0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .redirect        (redirect),
      .redirect_address(redirect_address),
      .misaligned      (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in-order memory: request seen at an edge answers lat cycles later
   always @(posedge clk) begin
      if (!rst) mq.delete();
      else if (bus.request) mq.push_back('{cyc + lat, bus.address_out});
      cyc++;
      #1;
      if (mq.size() != 0 && mq[0].due == cyc) begin
         bus.valid             = 1'b1;
         bus.instruction_fetch = ~mq[0].addr;
         void'(mq.pop_front());
      end else begin
         bus.valid             = 1'b0;
         bus.instruction_fetch = 32'h0;
      end
   end

   always @(posedge clk) if (rst && bus.request) issued++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; redirect = 1'b0; redirect_address = 32'h0;
      bus.instr_ready = 1'b1; lat = 1;
      repeat (2) @(negedge clk);
      chk("rst_request",     32'(bus.request),     32'h0);
      chk("rst_address",     bus.address_out,      32'h0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_instruction", bus.instruction,      32'h0);
      chk("rst_instr_pc",    bus.instr_pc,         32'h0);
      chk("rst_misaligned",  32'(misaligned),      32'h0);
      chk("rst_we_re",       32'(bus.we_re),       32'h0);
      chk("rst_mask",        32'(bus.mask),        32'hF);

      // streaming, latency 1, decode always ready
      rst = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("stream_request", 32'(bus.request), 32'h1);
         chk("stream_address", bus.address_out, 32'(4 * k));
         if (k >= 2) begin
            chk("stream_valid", 32'(bus.instr_valid), 32'h1);
            chk("stream_pc",    bus.instr_pc,    32'(4 * (k - 2)));
            chk("stream_data",  bus.instruction, ~32'(4 * (k - 2)));
         end else begin
            chk("stream_first_empty", 32'(bus.instr_valid), 32'h0);
         end
      end

      // fill with decode stalled: exactly DEPTH requests
      rst = 1'b0; bus.instr_ready = 1'b0; lat = 1;
      @(negedge clk);
      n0 = issued; rst = 1'b1;
      repeat (8) @(negedge clk);
      chk("full_issue_count", issued - n0,           32'd4);
      chk("full_request",     32'(bus.request),     32'h0);
      chk("full_head_valid",  32'(bus.instr_valid), 32'h1);
      chk("full_head_pc",     bus.instr_pc,         32'h0);
      bus.instr_ready = 1'b1;
      @(negedge clk);
      chk("pop_reissue_req",  32'(bus.request), 32'h1);
      chk("pop_reissue_addr", bus.address_out,  32'h10);
      chk("pop_head_pc",      bus.instr_pc,     32'h4);
      chk("pop_head_data",    bus.instruction,  32'hFFFF_FFFB);
      bus.instr_ready = 1'b0;
      n0 = issued;
      repeat (5) @(negedge clk);
      chk("pop_one_issue",    issued - n0,       32'd1);
      chk("pop_refull_req",   32'(bus.request), 32'h0);

      // latency 3, redirect with two requests in flight
      rst = 1'b0; bus.instr_ready = 1'b1; lat = 3;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("l3_addr4", bus.address_out, 32'h4);
      @(negedge clk);
      chk("l3_addr8", bus.address_out, 32'h8);
      redirect = 1'b1; redirect_address = 32'h100;
      #1;
      chk("redir_blocks_issue", 32'(bus.request), 32'h0);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("redir_resume_req",  32'(bus.request),     32'h1);
      chk("redir_resume_addr", bus.address_out,      32'h100);
      chk("redir_empty",       32'(bus.instr_valid), 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("stale_dropped", 32'(bus.instr_valid), 32'h0);
      end
      @(negedge clk);
      chk("redir_first_valid", 32'(bus.instr_valid), 32'h1);
      chk("redir_first_pc",    bus.instr_pc,         32'h100);
      chk("redir_first_data",  bus.instruction,      ~32'h100);
      @(negedge clk);
      chk("redir_second_pc",   bus.instr_pc,         32'h104);

      // latency 2, redirect coincident with response and pop
      rst = 1'b0; bus.instr_ready = 1'b1; lat = 2;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("coin_head_valid", 32'(bus.instr_valid), 32'h1);
      chk("coin_head_pc",    bus.instr_pc,         32'h0);
      redirect = 1'b1; redirect_address = 32'h40;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("coin_flushed", 32'(bus.instr_valid), 32'h0);
      chk("coin_addr",    bus.address_out,      32'h40);
      repeat (2) begin
         @(negedge clk);
         chk("coin_wait_empty", 32'(bus.instr_valid), 32'h0);
      end
      @(negedge clk);
      chk("coin_live_valid", 32'(bus.instr_valid), 32'h1);
      chk("coin_live_pc",    bus.instr_pc,         32'h40);
      chk("coin_live_data",  bus.instruction,      ~32'h40);

      // asynchronous reset with three entries queued
      rst = 1'b0; bus.instr_ready = 1'b0; lat = 1;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_reset_valid", 32'(bus.instr_valid), 32'h1);
      chk("pre_reset_pc",    bus.instr_pc,         32'h0);
      rst = 1'b0;
      #1;
      chk("async_valid", 32'(bus.instr_valid), 32'h0);
      chk("async_addr",  bus.address_out,      32'h0);
      chk("async_req",   32'(bus.request),     32'h0);
      chk("async_instr", bus.instruction,      32'h0);
      chk("async_pc",    bus.instr_pc,         32'h0);
      @(negedge clk);
      bus.instr_ready = 1'b1; rst = 1'b1;
      @(negedge clk);
      chk("restart_addr",  bus.address_out,      32'h4);
      chk("restart_empty", 32'(bus.instr_valid), 32'h0);
      @(negedge clk);
      chk("restart_valid", 32'(bus.instr_valid), 32'h1);
      chk("restart_pc",    bus.instr_pc,         32'h0);
      @(negedge clk);
      chk("restart_pc2",   bus.instr_pc,         32'h4);

      // misaligned redirect
      redirect = 1'b1; redirect_address = 32'h102;
      @(negedge clk);
      redirect = 1'b0;
      #1;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_flag", 32'(misaligned),  32'h1);
      chk("mis_req",  32'(bus.request), 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("mis_halted", 32'(bus.request),     32'h0);
         chk("mis_empty",  32'(bus.instr_valid), 32'h0);
      end
      redirect = 1'b1; redirect_address = 32'h200;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("mis_clear", 32'(misaligned),  32'h0);
      chk("mis_req2",  32'(bus.request), 32'h1);
      chk("mis_addr2", bus.address_out,  32'h200);
      repeat (2) @(negedge clk);
      chk("mis_pc2",   bus.instr_pc,     32'h200);
`else
      chk("align_flag", 32'(misaligned),  32'h0);
      chk("align_req",  32'(bus.request), 32'h1);
      chk("align_addr", bus.address_out,  32'h100);
      repeat (2) @(negedge clk);
      chk("align_valid", 32'(bus.instr_valid), 32'h1);
      chk("align_pc",    bus.instr_pc,         32'h100);
`endif

      // PC wrap at the top of the address space
      redirect = 1'b1; redirect_address = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      chk("wrap_addr_top", bus.address_out, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_addr_zero", bus.address_out, 32'h0);
      @(negedge clk);
      chk("wrap_pc_top",  bus.instr_pc,    32'hFFFF_FFFC);
      chk("wrap_data",    bus.instruction, 32'h3);
      @(negedge clk);
      chk("wrap_pc_zero", bus.instr_pc,    32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
